// File: rtl/reg_bank_wr_arbiter.sv
// reg_bank_wr_arbiter: round-robin write-port arbiter with locked bursts for the address-selected register bank
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/req_lock    per-requester request and burst-lock
//   req_addr/req_data     packed per-requester address and data
//   req_ready/req_err     registered grant and 1-cycle bad-address pulse
//   bank_addr/bank_d      registered bank write address/data (IDLE_ADDR when not writing)
module reg_bank_wr_arbiter #(
    parameter int NUM_REQ  = 3,
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 2,
    parameter int NUM_REGS = 3,
    parameter int LOCK_MAX = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_lock,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        req_err,
    output logic [ADDR_W-1:0]         bank_addr,
    output logic [DATA_W-1:0]         bank_d
);
    localparam int G_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int C_W = $clog2(LOCK_MAX) + 1;
    // The bank has no write enable, so this unmapped code means "no write"
    localparam logic [ADDR_W-1:0] IDLE_ADDR = ADDR_W'(NUM_REGS);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t             state, state_n;
    logic [G_W-1:0]     g, g_n, rr_ptr, rr_ptr_n, win;
    logic [C_W-1:0]     beat_cnt, beat_cnt_n;
    logic               found, xfer, bad, stay;
    logic [ADDR_W-1:0]  g_addr, addr_n;
    logic [DATA_W-1:0]  g_data, d_n;
    logic [NUM_REQ-1:0] g_oh, ready_n, err_n;

    assign g_addr = req_addr[g*ADDR_W +: ADDR_W];
    assign g_data = req_data[g*DATA_W +: DATA_W];
    assign g_oh   = NUM_REQ'(1) << g;
    assign xfer   = (state == GRANT) && req_valid[g];
    assign bad    = g_addr >= IDLE_ADDR;
    assign stay   = xfer && req_lock[g] && (beat_cnt < C_W'(LOCK_MAX - 1));

    // First valid requester after rr_ptr, wrapping; the last grantee is searched last
    always_comb begin
        win   = rr_ptr;
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            int idx;
            idx = (int'(rr_ptr) + k >= NUM_REQ) ? int'(rr_ptr) + k - NUM_REQ : int'(rr_ptr) + k;
            if (!found && req_valid[idx]) begin
                win   = G_W'(idx);
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            g         <= '0;
            rr_ptr    <= G_W'(NUM_REQ - 1);
            beat_cnt  <= '0;
            req_ready <= '0;
            req_err   <= '0;
            bank_addr <= IDLE_ADDR;
            bank_d    <= '0;
        end else begin
            state     <= state_n;
            g         <= g_n;
            rr_ptr    <= rr_ptr_n;
            beat_cnt  <= beat_cnt_n;
            req_ready <= ready_n;
            req_err   <= err_n;
            bank_addr <= addr_n;
            bank_d    <= d_n;
        end
    end

    // A missing valid while granted forfeits the grant just like a finished beat
    always_comb begin
        state_n = (state == IDLE) ? (found ? GRANT : IDLE) : (stay ? GRANT : IDLE);
    end

    always_comb begin
        g_n        = (state == IDLE && found) ? win : g;
        rr_ptr_n   = (state == GRANT && !stay) ? g : rr_ptr;
        beat_cnt_n = stay ? beat_cnt + 1'b1 : '0;
        ready_n    = (state_n == GRANT) ? NUM_REQ'(1) << g_n : '0;
        err_n      = (xfer && bad) ? g_oh : '0;
        addr_n     = (xfer && !bad) ? g_addr : IDLE_ADDR;
        d_n        = (xfer && !bad) ? g_data : bank_d;
    end
endmodule

// File: tb/tb_reg_bank_wr_arbiter.sv
// tb_reg_bank_wr_arbiter: scoreboard bench for reg_bank_wr_arbiter with a bank model fed from bank_addr/bank_d
module tb_reg_bank_wr_arbiter;
    typedef struct packed {
        logic [1:0] addr;
        logic [7:0] data;
        logic       lock;
    } beat_t;

    logic       clk;
    logic       rst_n;
    logic [2:0] req_valid;
    logic [2:0] req_lock;
    logic [5:0] req_addr;
    logic [23:0] req_data;
    logic [2:0] req_ready;
    logic [2:0] req_err;
    logic [1:0] bank_addr;
    logic [7:0] bank_d;

    reg_bank_wr_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_lock(req_lock),
        .req_addr(req_addr), .req_data(req_data),
        .req_ready(req_ready), .req_err(req_err),
        .bank_addr(bank_addr), .bank_d(bank_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    beat_t      beats[3][$];
    logic [2:0] exp_ready[$];
    logic [9:0] exp_wr[$];
    logic [2:0] exp_err[$];
    logic [7:0] q[3];
    logic [7:0] saved[3];
    logic [2:0] s_ready;
    logic [1:0] s_addr;
    logic [7:0] s_d;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input int r, input logic [1:0] a, input logic [7:0] d, input logic l);
        beats[r].push_back({a, d, l});
    endtask

    // One clock: monitor/scoreboard at negedge, requester drivers just after posedge
    task automatic cycle();
        logic [2:0] x;
        beat_t b;
        @(negedge clk);
        s_ready = req_ready;
        s_addr  = bank_addr;
        s_d     = bank_d;
        if (req_ready != 3'b000)
            check("ready", 32'(req_ready), exp_ready.size() ? 32'(exp_ready.pop_front()) : 32'(0));
        if (req_err != 3'b000)
            check("err", 32'(req_err), exp_err.size() ? 32'(exp_err.pop_front()) : 32'(0));
        if (bank_addr != 2'd3) begin
            check("write", 32'({bank_addr, bank_d}), exp_wr.size() ? 32'(exp_wr.pop_front()) : 32'hdead);
            q[bank_addr] = bank_d;
        end
        x = req_valid & req_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            if (x[i] && beats[i].size() > 0) b = beats[i].pop_front();
            if (beats[i].size() > 0) begin
                b = beats[i][0];
                req_valid[i]        = 1'b1;
                req_lock[i]         = b.lock;
                req_addr[i*2 +: 2]  = b.addr;
                req_data[i*8 +: 8]  = b.data;
            end else begin
                req_valid[i] = 1'b0;
                req_lock[i]  = 1'b0;
            end
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic drain(input string tag);
        run(8);
        check(tag, 32'(exp_ready.size() + exp_wr.size() + exp_err.size()), 32'(0));
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        req_lock  = '0;
        for (int i = 0; i < 3; i++) beats[i].delete();
        exp_ready.delete();
        exp_wr.delete();
        exp_err.delete();
        #1;
        check("rst_ready", 32'(req_ready), 32'(0));
        check("rst_err", 32'(req_err), 32'(0));
        check("rst_addr", 32'(bank_addr), 32'(3));
        check("rst_d", 32'(bank_d), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = '0;
        req_lock = '0;
        req_addr = '0;
        req_data = '0;
        q = '{8'h00, 8'h00, 8'h00};
        @(negedge clk);

        // 1: single write and its latency
        do_reset();
        push(0, 2'd1, 8'hA5, 1'b0);
        exp_ready.push_back(3'b001);
        exp_wr.push_back({2'd1, 8'hA5});
        cycle();
        cycle();
        check("t1_ready_early", 32'(s_ready), 32'(0));
        cycle();
        check("t1_ready", 32'(s_ready), 32'(3'b001));
        cycle();
        check("t1_addr", 32'(s_addr), 32'(1));
        check("t1_d", 32'(s_d), 32'(8'hA5));
        cycle();
        check("t1_idle_addr", 32'(s_addr), 32'(3));
        drain("t1_drain");
        check("t1_q1", 32'(q[1]), 32'(8'hA5));

        // 2: contention, grants 0,1,2
        do_reset();
        push(0, 2'd0, 8'h11, 1'b0);
        push(1, 2'd1, 8'h22, 1'b0);
        push(2, 2'd2, 8'h33, 1'b0);
        exp_ready = '{3'b001, 3'b010, 3'b100};
        exp_wr = '{{2'd0, 8'h11}, {2'd1, 8'h22}, {2'd2, 8'h33}};
        run(9);
        drain("t2_drain");
        check("t2_q0", 32'(q[0]), 32'(8'h11));
        check("t2_q1", 32'(q[1]), 32'(8'h22));
        check("t2_q2", 32'(q[2]), 32'(8'h33));

        // 3: fairness between 0 and 2, requester 1 idle
        do_reset();
        push(0, 2'd0, 8'h40, 1'b0);
        push(0, 2'd0, 8'h41, 1'b0);
        push(2, 2'd2, 8'h60, 1'b0);
        push(2, 2'd2, 8'h61, 1'b0);
        exp_ready = '{3'b001, 3'b100, 3'b001, 3'b100};
        exp_wr = '{{2'd0, 8'h40}, {2'd2, 8'h60}, {2'd0, 8'h41}, {2'd2, 8'h61}};
        run(12);
        drain("t3_drain");

        // 4: locked burst capped at 4 beats, then req0, then resume
        do_reset();
        for (int i = 1; i <= 6; i++) push(1, 2'd2, 8'(i), i != 6);
        cycle();
        push(0, 2'd0, 8'h77, 1'b0);
        exp_ready = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b001, 3'b010, 3'b010};
        exp_wr = '{{2'd2, 8'h01}, {2'd2, 8'h02}, {2'd2, 8'h03}, {2'd2, 8'h04},
                   {2'd0, 8'h77}, {2'd2, 8'h05}, {2'd2, 8'h06}};
        run(14);
        drain("t4_drain");
        check("t4_q2", 32'(q[2]), 32'(8'h06));
        check("t4_q0", 32'(q[0]), 32'(8'h77));

        // 5: out-of-range address
        do_reset();
        saved = q;
        push(2, 2'd3, 8'hFF, 1'b0);
        exp_ready.push_back(3'b100);
        exp_err.push_back(3'b100);
        run(6);
        drain("t5_drain");
        for (int i = 0; i < 3; i++) check("t5_q", 32'(q[i]), 32'(saved[i]));

        // 6: reset while requester 1 is readied
        do_reset();
        saved = q;
        push(1, 2'd1, 8'h99, 1'b0);
        cycle();
        cycle();
        check("t6_ready_pre", 32'(req_ready), 32'(3'b010));
        rst_n = 1'b0;
        #1;
        check("t6_rst_ready", 32'(req_ready), 32'(0));
        check("t6_rst_addr", 32'(bank_addr), 32'(3));
        beats[1].delete();
        req_valid = '0;
        req_lock = '0;
        run(2);
        @(negedge clk);
        rst_n = 1'b1;
        check("t6_q1", 32'(q[1]), 32'(saved[1]));
        push(1, 2'd2, 8'h55, 1'b0);
        push(0, 2'd0, 8'h66, 1'b0);
        exp_ready = '{3'b001, 3'b010};
        exp_wr = '{{2'd0, 8'h66}, {2'd2, 8'h55}};
        run(8);
        drain("t6_drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
